// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file sequencer/arbiter.
package regfile_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_LAST = REG_ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        DBG  = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_bypass.sv
// Forwarding mux for the registered read ports; compiled only when REGFILE_CTRL_BYPASS_EN is defined.
`ifdef REGFILE_CTRL_BYPASS_EN
module regfile_bypass
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                  lastWrite,
    input  logic [REG_ADDR_W-1:0] lastWrAddr,
    input  logic [XLEN-1:0]       lastWrData,
    input  logic [REG_ADDR_W-1:0] rdAddrA,
    input  logic [REG_ADDR_W-1:0] rdAddrB,
    input  logic [XLEN-1:0]       rfDataA,
    input  logic [XLEN-1:0]       rfDataB,
    output logic [XLEN-1:0]       fwdDataA,
    output logic [XLEN-1:0]       fwdDataB
);

    logic wrValid;
    logic hitA;
    logic hitB;

    // The regfile reads old data on a same-cycle write; substitute the write data instead.
    assign wrValid  = lastWrite && (lastWrAddr != REG_ZERO);
    assign hitA     = wrValid && (lastWrAddr == rdAddrA);
    assign hitB     = wrValid && (lastWrAddr == rdAddrB);
    assign fwdDataA = hitA ? lastWrData : rfDataA;
    assign fwdDataB = hitB ? lastWrData : rfDataB;

endmodule
`endif

// File: rtl/regfile_ctrl.sv
// Sequencer/arbiter in front of the 32-entry register file: zero-init, core/debug port sharing.
// Optional same-cycle write forwarding is enabled by defining REGFILE_CTRL_BYPASS_EN.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_wr_en,
    input  logic [REG_ADDR_W-1:0] core_wr_addr,
    input  logic [XLEN-1:0]       core_wr_data,
    input  logic [REG_ADDR_W-1:0] core_rd_addr_a,
    input  logic [REG_ADDR_W-1:0] core_rd_addr_b,
    output logic [XLEN-1:0]       core_rd_data_a,
    output logic [XLEN-1:0]       core_rd_data_b,
    output logic                  core_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    input  logic [XLEN-1:0]       dbg_wdata,
    output logic                  dbg_ack,
    output logic [XLEN-1:0]       dbg_rdata,
    output logic                  rf_write,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [XLEN-1:0]       rf_wr_data,
    output logic [REG_ADDR_W-1:0] rf_rd_addr_a,
    output logic [REG_ADDR_W-1:0] rf_rd_addr_b,
    input  logic [XLEN-1:0]       rf_rd_data_a,
    input  logic [XLEN-1:0]       rf_rd_data_b
);

    localparam int unsigned CNT_W = 8;

    state_t                state;
    state_t                stateNext;
    logic [REG_ADDR_W-1:0] initPtr;
    logic [REG_ADDR_W-1:0] initPtrNext;
    logic [CNT_W-1:0]      starveCnt;
    logic [CNT_W-1:0]      starveCntNext;
    logic                  dbgPhase;
    logic                  dbgPhaseNext;
    logic                  wrReq;

    logic [REG_ADDR_W-1:0] rdAddrAQ;
    logic [REG_ADDR_W-1:0] rdAddrBQ;
    logic [XLEN-1:0]       holdA;
    logic [XLEN-1:0]       holdB;
    logic [XLEN-1:0]       fwdA;
    logic [XLEN-1:0]       fwdB;
    logic [XLEN-1:0]       freshA;
    logic [XLEN-1:0]       freshB;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT;
            initPtr   <= 5'd1;
            starveCnt <= '0;
            dbgPhase  <= 1'b0;
        end else begin
            state     <= stateNext;
            initPtr   <= initPtrNext;
            starveCnt <= starveCntNext;
            dbgPhase  <= dbgPhaseNext;
        end
    end

    // Next-state and port steering
    always_comb begin
        stateNext     = state;
        initPtrNext   = initPtr;
        starveCntNext = starveCnt;
        dbgPhaseNext  = 1'b0;
        wrReq         = 1'b0;
        rf_wr_addr    = core_wr_addr;
        rf_wr_data    = core_wr_data;
        rf_rd_addr_a  = core_rd_addr_a;
        rf_rd_addr_b  = core_rd_addr_b;
        core_stall    = 1'b1;
        dbg_ack       = 1'b0;
        dbg_rdata     = '0;

        unique case (state)
            INIT: begin
                wrReq       = 1'b1;
                rf_wr_addr  = initPtr;
                rf_wr_data  = '0;
                initPtrNext = initPtr + 5'd1;
                if (initPtr == REG_LAST) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                core_stall = 1'b0;
                wrReq      = core_wr_en;
                // Core writeback has priority until the debug request has starved long enough.
                if (dbg_req) begin
                    if (!core_wr_en || (starveCnt == CNT_W'(STARVE_LIMIT))) begin
                        stateNext     = DBG;
                        starveCntNext = '0;
                    end else begin
                        starveCntNext = starveCnt + 8'd1;
                    end
                end
            end
            DBG: begin
                if (!dbgPhase) begin
                    rf_rd_addr_a = dbg_addr;
                    wrReq        = dbg_we;
                    rf_wr_addr   = dbg_addr;
                    rf_wr_data   = dbg_wdata;
                    dbgPhaseNext = 1'b1;
                end else begin
                    dbg_ack   = 1'b1;
                    stateNext = RUN;
                    if (dbg_we) begin
                        dbg_rdata = dbg_wdata;
                    end else if (dbg_addr != REG_ZERO) begin
                        dbg_rdata = rf_rd_data_a;
                    end
                end
            end
            default: begin
                stateNext = INIT;
            end
        endcase
    end

    // x0 is never written; a held reset also suppresses writes.
    assign rf_write = wrReq && rst_n && (rf_wr_addr != REG_ZERO);

    // Read addresses and last delivered operands, aligned with the regfile's read latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdAddrAQ <= REG_ZERO;
            rdAddrBQ <= REG_ZERO;
            holdA    <= '0;
            holdB    <= '0;
        end else begin
            rdAddrAQ <= rf_rd_addr_a;
            rdAddrBQ <= rf_rd_addr_b;
            holdA    <= core_rd_data_a;
            holdB    <= core_rd_data_b;
        end
    end

`ifdef REGFILE_CTRL_BYPASS_EN
    logic                  lastWrite;
    logic [REG_ADDR_W-1:0] lastWrAddr;
    logic [XLEN-1:0]       lastWrData;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lastWrite  <= 1'b0;
            lastWrAddr <= REG_ZERO;
            lastWrData <= '0;
        end else begin
            lastWrite  <= rf_write;
            lastWrAddr <= rf_wr_addr;
            lastWrData <= rf_wr_data;
        end
    end

    regfile_bypass #(
        .XLEN(XLEN)
    ) uBypass (
        .lastWrite  (lastWrite),
        .lastWrAddr (lastWrAddr),
        .lastWrData (lastWrData),
        .rdAddrA    (rdAddrAQ),
        .rdAddrB    (rdAddrBQ),
        .rfDataA    (rf_rd_data_a),
        .rfDataB    (rf_rd_data_b),
        .fwdDataA   (fwdA),
        .fwdDataB   (fwdB)
    );
`else
    assign fwdA = rf_rd_data_a;
    assign fwdB = rf_rd_data_b;
`endif

    // x0 storage is never initialised, so its reads are masked here.
    assign freshA = (rdAddrAQ == REG_ZERO) ? '0 : fwdA;
    assign freshB = (rdAddrBQ == REG_ZERO) ? '0 : fwdB;

    assign core_rd_data_a = core_stall ? holdA : freshA;
    assign core_rd_data_b = core_stall ? holdB : freshB;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed self-checking bench for regfile_ctrl with a behavioural 32x32 register file model.
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_wr_en;
    logic [4:0]  core_wr_addr;
    logic [31:0] core_wr_data;
    logic [4:0]  core_rd_addr_a;
    logic [4:0]  core_rd_addr_b;
    logic [31:0] core_rd_data_a;
    logic [31:0] core_rd_data_b;
    logic        core_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        rf_write;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [4:0]  rf_rd_addr_a;
    logic [4:0]  rf_rd_addr_b;
    logic [31:0] rf_rd_data_a;
    logic [31:0] rf_rd_data_b;

    logic [31:0] mem [32];
    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    regfile_ctrl #(
        .XLEN(32),
        .STARVE_LIMIT(8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_wr_en     (core_wr_en),
        .core_wr_addr   (core_wr_addr),
        .core_wr_data   (core_wr_data),
        .core_rd_addr_a (core_rd_addr_a),
        .core_rd_addr_b (core_rd_addr_b),
        .core_rd_data_a (core_rd_data_a),
        .core_rd_data_b (core_rd_data_b),
        .core_stall     (core_stall),
        .dbg_req        (dbg_req),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_ack        (dbg_ack),
        .dbg_rdata      (dbg_rdata),
        .rf_write       (rf_write),
        .rf_wr_addr     (rf_wr_addr),
        .rf_wr_data     (rf_wr_data),
        .rf_rd_addr_a   (rf_rd_addr_a),
        .rf_rd_addr_b   (rf_rd_addr_b),
        .rf_rd_data_a   (rf_rd_data_a),
        .rf_rd_data_b   (rf_rd_data_b)
    );

    // Register file: registered reads return pre-write contents on a same-cycle write.
    always @(posedge clk) begin
        rf_rd_data_a <= mem[rf_rd_addr_a];
        rf_rd_data_b <= mem[rf_rd_addr_b];
        if (rf_write) mem[rf_wr_addr] <= rf_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        rst_n = 1'b0;
        core_wr_en = 1'b0; core_wr_addr = 5'd0; core_wr_data = 32'h0;
        core_rd_addr_a = 5'd0; core_rd_addr_b = 5'd0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'h0;
        step();
        step();
        #1;
        chk("rst_stall", 32'(core_stall), 32'd1);
        chk("rst_ack", 32'(dbg_ack), 32'd0);
        chk("rst_rdata", dbg_rdata, 32'h0);
        chk("rst_rfwrite", 32'(rf_write), 32'd0);
        chk("rst_rda", core_rd_data_a, 32'h0);
        chk("rst_rdb", core_rd_data_b, 32'h0);

        // 1: zero-init sweep x1..x31
        rst_n = 1'b1;
        #1;
        for (int i = 1; i <= 31; i++) begin
            chk("init_wr", {25'd0, rf_write, rf_wr_addr, core_stall}, {25'd0, 1'b1, 5'(i), 1'b1});
            chk("init_data", rf_wr_data, 32'h0);
            step();
            #1;
        end
        chk("run_stall", 32'(core_stall), 32'd0);
        chk("run_nowrite", 32'(rf_write), 32'd0);

        // 2: same-cycle write/read of x5
        core_wr_en = 1'b1; core_wr_addr = 5'd5; core_wr_data = 32'hDEAD_BEEF;
        core_rd_addr_a = 5'd5; core_rd_addr_b = 5'd0;
        #1;
        chk("c0_write", {26'd0, rf_write, rf_wr_addr}, {26'd0, 1'b1, 5'd5});
        chk("c0_rdaddr", 32'(rf_rd_addr_a), 32'd5);
        step();
        core_wr_en = 1'b0;
        #1;
`ifdef REGFILE_CTRL_BYPASS_EN
        chk("bypass_a", core_rd_data_a, 32'hDEAD_BEEF);
`else
        chk("nobypass_a", core_rd_data_a, 32'h0);
`endif
        chk("x0_core_b", core_rd_data_b, 32'h0);
        step();
        // 3: debug read of x5 while core idle
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        #1;
        chk("x5_settled", core_rd_data_a, 32'hDEAD_BEEF);
        chk("dr_grant_stall", 32'(core_stall), 32'd0);
        step();
        #1;
        chk("dr_c1_stall", 32'(core_stall), 32'd1);
        chk("dr_c1_ack", 32'(dbg_ack), 32'd0);
        chk("dr_c1_addr", 32'(rf_rd_addr_a), 32'd5);
        chk("dr_c1_hold", core_rd_data_a, 32'hDEAD_BEEF);
        step();
        #1;
        chk("dr_c2_ack", 32'(dbg_ack), 32'd1);
        chk("dr_c2_rdata", dbg_rdata, 32'hDEAD_BEEF);
        chk("dr_c2_stall", 32'(core_stall), 32'd1);
        dbg_req = 1'b0;
        step();
        #1;
        chk("dr_done_ack", 32'(dbg_ack), 32'd0);
        chk("dr_done_stall", 32'(core_stall), 32'd0);
        chk("dr_done_rda", core_rd_data_a, 32'hDEAD_BEEF);

        // 4: starvation -- core writes x7 every cycle, debug write to x9 pending
        core_wr_en = 1'b1; core_wr_addr = 5'd7; core_wr_data = 32'h7777_0007;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h0000_0099;
        #1;
        for (int k = 1; k <= 9; k++) begin
            chk("starve_run", {30'd0, core_stall, dbg_ack}, 32'd0);
            step();
            #1;
        end
        chk("starve_grant", 32'(core_stall), 32'd1);
        chk("starve_dbgwr", {26'd0, rf_write, rf_wr_addr}, {26'd0, 1'b1, 5'd9});
        chk("starve_dbgdata", rf_wr_data, 32'h0000_0099);
        step();
        #1;
        chk("starve_ack", 32'(dbg_ack), 32'd1);
        chk("starve_rdata", dbg_rdata, 32'h0000_0099);
        chk("starve_c2_nowr", 32'(rf_write), 32'd0);
        dbg_req = 1'b0;
        step();
        #1;
        chk("starve_resume", {26'd0, rf_write, rf_wr_addr}, {26'd0, 1'b1, 5'd7});
        chk("starve_resume_st", 32'(core_stall), 32'd0);
        core_wr_en = 1'b0;
        core_rd_addr_a = 5'd9; core_rd_addr_b = 5'd7;
        step();
        #1;
        chk("rd_x9", core_rd_data_a, 32'h0000_0099);
        chk("rd_x7", core_rd_data_b, 32'h7777_0007);

        // 5: writes to x0 from core and debug are blocked
        core_wr_en = 1'b1; core_wr_addr = 5'd0; core_wr_data = 32'hFFFF_FFFF;
        #1;
        chk("core_x0_wr", 32'(rf_write), 32'd0);
        step();
        core_wr_en = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'h0000_1234;
        step();
        #1;
        chk("dbg_x0_wr", 32'(rf_write), 32'd0);
        chk("dbg_x0_stall", 32'(core_stall), 32'd1);
        step();
        #1;
        chk("dbg_x0_ack", 32'(dbg_ack), 32'd1);
        chk("dbg_x0_rdata", dbg_rdata, 32'h0000_1234);
        dbg_req = 1'b0;
        core_rd_addr_a = 5'd0;
        step();
        #1;
        chk("core_x0_rd", core_rd_data_a, 32'h0);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd0;
        step();
        step();
        #1;
        chk("dbg_x0_rd_ack", 32'(dbg_ack), 32'd1);
        chk("dbg_x0_rd", dbg_rdata, 32'h0);
        dbg_req = 1'b0;
        step();

        // 6: reset during debug cycle 1 drops the access and restarts init
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'h0000_0033;
        step();
        #1;
        chk("r6_dbg_c1", 32'(core_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("r6_nowrite", 32'(rf_write), 32'd0);
        step();
        #1;
        chk("r6_noack", 32'(dbg_ack), 32'd0);
        chk("r6_rdata", dbg_rdata, 32'h0);
        chk("r6_rda", core_rd_data_a, 32'h0);
        rst_n = 1'b1;
        dbg_req = 1'b0;
        #1;
        chk("r6_init1", {26'd0, rf_write, rf_wr_addr}, {26'd0, 1'b1, 5'd1});
        step();
        #1;
        chk("r6_init2", {26'd0, rf_write, rf_wr_addr}, {26'd0, 1'b1, 5'd2});
        chk("r6_x3_kept", mem[3], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
